hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS pipeline. It generates the `hold` and `flush_IFID` controls for the IF/ID register, the matching PC hold and ID/EX bubble, and tracks the multi-cycle multiply/divide unit. All decisions are a same-cycle combinational function of the registered state and the current-cycle inputs. A saturating stall counter is kept for performance debug.

## Interface
- `MD_LATENCY`, default 32: cycles the mult/div unit stays busy after issue; legal range 1 to 2^CNT_W−1.
- `CNT_W`, default 6: width of the busy countdown.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rs_ID`  in  5  rs field of the instruction in ID.
- `rt_ID`  in  5  rt field of the instruction in ID.
- `UseRt_ID`  in  1  ID instruction reads rt as a source.
- `MemRead_EX`  in  1  EX instruction is a load.
- `WriteReg_EX`  in  5  destination register of the EX instruction.
- `BranchTaken_EX`  in  1  branch in EX resolved taken.
- `Jump_ID`  in  1  ID instruction is j/jal/jr/jalr.
- `MulDiv_ID`  in  1  ID instruction is mult/multu/div/divu.
- `ReadHiLo_ID`  in  1  ID instruction is mfhi/mflo.
- `hold_PC`  out  1  freeze PC.
- `hold`  out  1  freeze the IF/ID register.
- `flush_IFID`  out  1  zero the IF/ID register.
- `flush_IDEX`  out  1  insert a bubble into ID/EX.
- `md_busy`  out  1  mult/div unit busy.
- `stall_cnt`  out  16  saturating count of stall cycles.

## Operation
- State FSM with two states:
  - IDLE: counter = 0.
  - MD_BUSY: counter = cycles remaining.
- Definitions:
  - `lu` (load-use) = MemRead_EX & WriteReg_EX≠0 & (WriteReg_EX==rs_ID | (UseRt_ID & WriteReg_EX==rt_ID)).
  - `md` (mult/div conflict) = (state==MD_BUSY) & (MulDiv_ID | ReadHiLo_ID).
  - `stall` = (lu | md) & ~BranchTaken_EX.
- Priority, highest first:
  1. BranchTaken_EX: flush_IFID=1, flush_IDEX=1; hold_PC=0, hold=0. Redirect wins over every stall.
  2. stall: hold_PC=1, hold=1, flush_IDEX=1, flush_IFID=0.
  3. Jump_ID without stall: flush_IFID=1; all others 0.
  4. Otherwise all four controls are 0.
- A jump that is also stalled stays held in ID and is flushed on the first unstalled cycle.
- Mult/div issue:
  - Issue occurs when MulDiv_ID=1, stall=0 and BranchTaken_EX=0.
  - On issue, the counter is loaded with MD_LATENCY and state becomes MD_BUSY.
  - A mult/div in ID while busy stalls until the unit frees; it is not queued.
- In MD_BUSY:
  - The counter decrements every cycle.
  - When the counter is 1, the next state is IDLE with counter 0.
  - A taken branch does not cancel a mult/div that has already issued.
- md_busy = (state==MD_BUSY).
- stall_cnt increments on each cycle with stall=1 and saturates at 0xFFFF.
- Width rules:
  - The counter is CNT_W bits wide, is loaded from MD_LATENCY truncated to CNT_W, and never wraps.
  - stall_cnt never wraps.

## Timing
- Reset:
  - While reset=1, all control outputs are forced to 0.
  - At the next edge: state=IDLE, counter=0, md_busy=0, stall_cnt=0.
  - A reset during MD_BUSY aborts it immediately.
- Control outputs have zero-cycle latency: they are valid in the same cycle as their inputs.
- Load-use stalls last exactly 1 cycle. In the following cycle the load is in MEM, so lu deasserts.
- md_busy rises on the edge after issue and stays high for exactly MD_LATENCY cycles.
  - With MD_LATENCY=1, md_busy is high for a single cycle.
- The earliest HiLo read proceeds in the first cycle after md_busy falls.
- Simultaneous events:
  - Branch + lu in the same cycle: flush only, and stall_cnt does not increment.
  - Issue + a mult/div already finishing (counter==1): not possible, because a busy unit blocks issue. A MulDiv_ID in that cycle stalls and issues in the next cycle.

## Test plan
- Reset:
  - Stimulus: assert reset for 2 cycles while MulDiv_ID=1.
  - Required: all outputs 0, then state IDLE, md_busy=0, stall_cnt=0.
- Load-use:
  - Stimulus: MemRead_EX=1, WriteReg_EX=5, rs_ID=5.
  - Required: hold_PC=hold=flush_IDEX=1 for 1 cycle; stall_cnt=1.
  - Variation: WriteReg_EX=0 → no stall.
- Branch overrides stall:
  - Stimulus: load-use condition plus BranchTaken_EX=1.
  - Required: flush_IFID=flush_IDEX=1, hold=0, stall_cnt unchanged.
- Jump under stall:
  - Stimulus: Jump_ID=1 with lu for 1 cycle.
  - Required: cycle 0 hold=1, flush_IFID=0; cycle 1 flush_IFID=1.
- Mult/div busy window:
  - Stimulus: MD_LATENCY=4; issue MulDiv_ID, then ReadHiLo_ID continuously.
  - Required: md_busy high for 4 cycles; hold high for those 4 cycles; the read proceeds in cycle 5; stall_cnt=4.
- Abort and saturation:
  - Stimulus 1: reset at counter=2 during MD_BUSY.
    - Required: IDLE next cycle.
  - Stimulus 2: force 65540 stall cycles.
    - Required: stall_cnt=0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// hazard_ctrl: load-use / branch / jump / mult-div hazard control
// Rev 1.0
// ------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        UseRt_ID,
  input  logic        MemRead_EX,
  input  logic [4:0]  WriteReg_EX,
  input  logic        BranchTaken_EX,
  input  logic        Jump_ID,
  input  logic        MulDiv_ID,
  input  logic        ReadHiLo_ID,
  output logic        hold_PC,
  output logic        hold,
  output logic        flush_IFID,
  output logic        flush_IDEX,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MD_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_LAT = CNT_W'(MD_LATENCY);
  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      r_stall_cnt;
  logic             w_lu;
  logic             w_md;
  logic             w_stall;
  logic             w_issue;

  assign w_lu    = MemRead_EX & (WriteReg_EX != 5'd0) &
                   ((WriteReg_EX == rs_ID) | (UseRt_ID & (WriteReg_EX == rt_ID)));
  assign w_md    = (r_state == S_MD_BUSY) & (MulDiv_ID | ReadHiLo_ID);
  assign w_stall = (w_lu | w_md) & ~BranchTaken_EX;
  assign w_issue = MulDiv_ID & ~w_stall & ~BranchTaken_EX;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // A busy unit always stalls a new MulDiv, so issue is only seen from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = S_MD_BUSY;
          w_cnt_nxt   = c_LAT;
        end
      end
      S_MD_BUSY: begin
        if (r_cnt <= c_ONE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    hold_PC    = 1'b0;
    hold       = 1'b0;
    flush_IFID = 1'b0;
    flush_IDEX = 1'b0;
    if (!reset) begin
      if (BranchTaken_EX) begin
        flush_IFID = 1'b1;
        flush_IDEX = 1'b1;
      end else if (w_stall) begin
        hold_PC    = 1'b1;
        hold       = 1'b1;
        flush_IDEX = 1'b1;
      end else if (Jump_ID) begin
        flush_IFID = 1'b1;
      end
    end
  end

  assign md_busy   = (r_state == S_MD_BUSY);
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
